// File: rtl/sram_wishbone_initiator.sv
// sram_wishbone_initiator: Wishbone classic responder driving an SRAM RW port,
// with a built-in engine that writes a pattern to every word.
module sram_wishbone_initiator #(
  parameter int BYTE_COUNT   = 4,
  parameter int ADDRESS_SIZE = 9,
  localparam int WORD_SIZE   = 8 * BYTE_COUNT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wbCyc,
  input  logic                    wbStb,
  input  logic                    wbWe,
  input  logic [BYTE_COUNT-1:0]   wbSel,
  input  logic [ADDRESS_SIZE-1:0] wbAddress,
  input  logic [WORD_SIZE-1:0]    wbDataWrite,
  output logic                    wbAck,
  output logic [WORD_SIZE-1:0]    wbDataRead,
  input  logic                    fillStart,
  input  logic [WORD_SIZE-1:0]    fillPattern,
  output logic                    fillBusy,
  output logic                    fillDone,
  output logic                    sramSelect,
  output logic                    sramWriteEnable,
  output logic [BYTE_COUNT-1:0]   sramWriteMask,
  output logic [ADDRESS_SIZE-1:0] sramAddress,
  output logic [WORD_SIZE-1:0]    sramDataWrite,
  input  logic [WORD_SIZE-1:0]    sramDataRead
);
  typedef enum logic [2:0] {IDLE, ACCESS, READ_WAIT, ACK, FILL} state_t;
  state_t                  r_state, w_state;
  logic                    r_ack, w_ack, r_busy, w_busy, r_done, w_done;
  logic                    r_sel, w_sel, r_we, w_we, r_pend, w_pend;
  logic [BYTE_COUNT-1:0]   r_mask, w_mask;
  logic [ADDRESS_SIZE-1:0] r_addr, w_addr;
  logic [WORD_SIZE-1:0]    r_wdata, w_wdata, r_rdata, w_rdata;
  always_comb begin
    w_state = r_state;
    w_ack   = r_ack;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_sel   = r_sel;
    w_we    = r_we;
    w_mask  = r_mask;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_rdata = r_rdata;
    // a fill request arriving during a bus access is held until IDLE; during a fill it is dropped
    w_pend  = r_pend | (fillStart & (r_state != FILL));
    case (r_state)
      IDLE: begin
        if (fillStart | r_pend) begin
          w_pend  = 1'b0;
          w_wdata = fillPattern;
          w_sel   = 1'b1;
          w_we    = 1'b1;
          w_mask  = '1;
          w_addr  = '0;
          w_busy  = 1'b1;
          w_state = FILL;
        end else if (wbCyc & wbStb) begin
          w_sel   = 1'b1;
          w_we    = wbWe;
          w_mask  = wbWe ? wbSel : '0;
          w_addr  = wbAddress;
          w_wdata = wbDataWrite;
          w_state = ACCESS;
        end
      end
      ACCESS: begin
        w_sel   = 1'b0;
        w_we    = 1'b0;
        w_ack   = r_we & wbCyc;
        w_state = r_we ? ACK : READ_WAIT;
      end
      READ_WAIT: begin
        w_ack   = wbCyc;
        w_rdata = wbCyc ? sramDataRead : r_rdata;
        w_state = ACK;
      end
      ACK: begin
        w_ack   = 1'b0;
        w_state = IDLE;
      end
      FILL: begin
        if (r_addr == '1) begin
          w_sel   = 1'b0;
          w_we    = 1'b0;
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_state = IDLE;
        end else begin
          w_addr = r_addr + 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sel   <= 1'b0;
      r_we    <= 1'b0;
      r_pend  <= 1'b0;
      r_mask  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state;
      r_ack   <= w_ack;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_sel   <= w_sel;
      r_we    <= w_we;
      r_pend  <= w_pend;
      r_mask  <= w_mask;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_rdata <= w_rdata;
    end
  end
  assign wbAck           = r_ack;
  assign wbDataRead      = r_rdata;
  assign fillBusy        = r_busy;
  assign fillDone        = r_done;
  assign sramSelect      = r_sel;
  assign sramWriteEnable = r_we;
  assign sramWriteMask   = r_mask;
  assign sramAddress     = r_addr;
  assign sramDataWrite   = r_wdata;
endmodule

// File: tb/tb_sram_wishbone_initiator.sv
// tb_sram_wishbone_initiator: directed bench with an SRAM model and an ack scoreboard.
module tb_sram_wishbone_initiator;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wbCyc, wbStb, wbWe, wbAck, fillStart, fillBusy, fillDone;
  logic [3:0]  wbSel, sramWriteMask;
  logic [8:0]  wbAddress, sramAddress;
  logic [31:0] wbDataWrite, wbDataRead, fillPattern, sramDataWrite, sramDataRead;
  logic        sramSelect, sramWriteEnable;

  sram_wishbone_initiator #(.BYTE_COUNT(4), .ADDRESS_SIZE(9)) dut (
    .clk(clk), .rst(rst), .wbCyc(wbCyc), .wbStb(wbStb), .wbWe(wbWe), .wbSel(wbSel),
    .wbAddress(wbAddress), .wbDataWrite(wbDataWrite), .wbAck(wbAck), .wbDataRead(wbDataRead),
    .fillStart(fillStart), .fillPattern(fillPattern), .fillBusy(fillBusy), .fillDone(fillDone),
    .sramSelect(sramSelect), .sramWriteEnable(sramWriteEnable), .sramWriteMask(sramWriteMask),
    .sramAddress(sramAddress), .sramDataWrite(sramDataWrite), .sramDataRead(sramDataRead)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:511];
  always @(posedge clk) begin
    if (sramSelect) begin
      if (sramWriteEnable) begin
        for (int b = 0; b < 4; b++) begin
          if (sramWriteMask[b]) mem[sramAddress][8*b +: 8] <= sramDataWrite[8*b +: 8];
        end
      end else begin
        sramDataRead <= mem[sramAddress];
      end
    end
  end

  typedef struct {logic rd; logic [31:0] data; int t0; int lat;} exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_fail = 0, cyc = 0, fill_starts = 0, done_cnt = 0;
  logic busy_q = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (fillBusy && !busy_q) fill_starts++;
    if (fillDone) done_cnt++;
    busy_q = fillBusy;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // scoreboard monitor: every ack must match the oldest outstanding request
  always @(negedge clk) begin
    if (rst && wbAck) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack with no request outstanding, expected none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.rd) check("read_data", wbDataRead, e.data);
        if (e.lat >= 0) check("ack_latency", cyc - e.t0, e.lat);
      end
    end
  end

  // called at a negedge while the DUT is idle; returns one negedge after the ack
  task automatic bus_op(input logic we, input logic [3:0] sel, input logic [8:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp, input int lat);
    exp_t e;
    logic got;
    e.rd = !we; e.data = exp; e.t0 = cyc; e.lat = lat;
    sb.push_back(e);
    wbCyc = 1'b1; wbStb = 1'b1; wbWe = we; wbSel = sel; wbAddress = addr; wbDataWrite = wd;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      got = wbAck;
    end
    wbCyc = 1'b0; wbStb = 1'b0;
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL bus_timeout addr=%h: got no ack, expected ack", addr);
    end
    @(negedge clk);
  endtask

  task automatic run_fill(input logic [31:0] pat);
    int cnt;
    logic ok, got;
    fillStart = 1'b1; fillPattern = pat;
    @(negedge clk);
    fillStart = 1'b0;
    cnt = 0; ok = 1'b1; got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      if (fillDone) got = 1'b1;
      else begin
        if (sramSelect) begin
          if (!(sramWriteEnable && sramAddress == cnt[8:0] && sramWriteMask == 4'hF && sramDataWrite == pat)) ok = 1'b0;
          cnt++;
        end
        @(negedge clk);
      end
    end
    check("fill_select_cycles", cnt, 512);
    check("fill_order", ok, 1);
    check("fill_done_seen", got, 1);
    check("fill_busy_cleared", fillBusy, 0);
    @(negedge clk);
    check("fill_done_pulse", fillDone, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0;
    logic seen, found;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    sramDataRead = '0;
    rst = 1'b0; wbCyc = 1'b1; wbStb = 1'b1; wbWe = 1'b1; wbSel = 4'hF; wbAddress = 9'h005;
    wbDataWrite = 32'h12345678; fillStart = 1'b1; fillPattern = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    check("rst_wbAck", wbAck, 0);
    check("rst_wbDataRead", wbDataRead, 0);
    check("rst_fillBusy", fillBusy, 0);
    check("rst_fillDone", fillDone, 0);
    check("rst_sramSelect", sramSelect, 0);
    check("rst_sramWriteEnable", sramWriteEnable, 0);
    check("rst_sramWriteMask", sramWriteMask, 0);
    check("rst_sramAddress", sramAddress, 0);
    check("rst_sramDataWrite", sramDataWrite, 0);
    wbCyc = 1'b0; wbStb = 1'b0; fillStart = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= sramSelect | fillBusy | wbAck;
    end
    check("idle_after_reset", seen, 0);

    bus_op(1'b1, 4'hF, 9'h1A5, 32'hDEADBEEF, 32'h0, 2);
    bus_op(1'b0, 4'h0, 9'h1A5, 32'h0, 32'hDEADBEEF, 3);

    bus_op(1'b1, 4'hF, 9'h010, 32'h11223344, 32'h0, 2);
    bus_op(1'b1, 4'h5, 9'h010, 32'hAABBCCDD, 32'h0, 2);
    bus_op(1'b0, 4'h0, 9'h010, 32'h0, 32'h11BB33DD, 3);
    bus_op(1'b1, 4'h0, 9'h010, 32'hFFFFFFFF, 32'h0, 2);
    bus_op(1'b0, 4'h0, 9'h010, 32'h0, 32'h11BB33DD, 3);

    run_fill(32'hA5A5A5A5);
    bus_op(1'b0, 4'h0, 9'h000, 32'h0, 32'hA5A5A5A5, 3);
    bus_op(1'b0, 4'h0, 9'h100, 32'h0, 32'hA5A5A5A5, 3);
    bus_op(1'b0, 4'h0, 9'h1FF, 32'h0, 32'hA5A5A5A5, 3);
    bus_op(1'b0, 4'h0, 9'h1A5, 32'h0, 32'hA5A5A5A5, 3);

    s0 = fill_starts; d0 = done_cnt;
    fillStart = 1'b1; fillPattern = 32'h5A5A5A5A;
    fork
      bus_op(1'b0, 4'h0, 9'h0AB, 32'h0, 32'h5A5A5A5A, -1);
      begin
        @(negedge clk);
        fillStart = 1'b0;
        repeat (100) @(negedge clk);
        check("contention_fill_running", fillBusy, 1);
        fillStart = 1'b1; fillPattern = 32'h12345678;
        @(negedge clk);
        fillStart = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    check("contention_one_fill", fill_starts - s0, 1);
    check("contention_one_done", done_cnt - d0, 1);
    check("contention_idle", fillBusy, 0);
    bus_op(1'b0, 4'h0, 9'h1FF, 32'h0, 32'h5A5A5A5A, 3);

    bus_op(1'b1, 4'hF, 9'h1A5, 32'hCAFEF00D, 32'h0, 2);
    bus_op(1'b0, 4'h0, 9'h1A5, 32'h0, 32'hCAFEF00D, 3);
    bus_op(1'b1, 4'hF, 9'h1A5, 32'h0BADC0DE, 32'h0, 2);
    wbCyc = 1'b1; wbStb = 1'b1; wbWe = 1'b0; wbSel = 4'h0; wbAddress = 9'h1A5;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen |= wbAck;
    end
    wbCyc = 1'b0; wbStb = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen |= wbAck;
    end
    check("abort_no_ack", seen, 0);
    check("abort_data_held", wbDataRead, 32'hCAFEF00D);
    bus_op(1'b0, 4'h0, 9'h1A5, 32'h0, 32'h0BADC0DE, 3);

    bus_op(1'b1, 4'hF, 9'h064, 32'h10010010, 32'h0, 2);
    bus_op(1'b1, 4'hF, 9'h12C, 32'h30030030, 32'h0, 2);
    d0 = done_cnt;
    fillStart = 1'b1; fillPattern = 32'hC3C3C3C3;
    @(negedge clk);
    fillStart = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (sramSelect && sramAddress == 9'd100) found = 1'b1;
      else @(negedge clk);
    end
    check("reach_fill_addr_100", found, 1);
    rst = 1'b0;
    #1;
    check("midfill_rst_busy", fillBusy, 0);
    check("midfill_rst_select", sramSelect, 0);
    check("midfill_rst_address", sramAddress, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midfill_no_done", done_cnt - d0, 0);
    check("midfill_stays_idle", fillBusy, 0);
    bus_op(1'b0, 4'h0, 9'h063, 32'h0, 32'hC3C3C3C3, 3);
    bus_op(1'b0, 4'h0, 9'h064, 32'h0, 32'h10010010, 3);
    bus_op(1'b0, 4'h0, 9'h12C, 32'h0, 32'h30030030, 3);
    bus_op(1'b0, 4'h0, 9'h000, 32'h0, 32'hC3C3C3C3, 3);

    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
